// File: rtl/haz_pkg.sv
// Shared encodings for the hazard controller: forward selects, the load
// result-source code and the memory-wait FSM states.
package haz_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FAULT
  } state_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select for the execute stage; the M-stage result
// wins over W because it is the younger write to the same register.
module fwd_sel
  import haz_pkg::*;
(
  input  logic [4:0] rsE_i,
  input  logic [4:0] rdM_i,
  input  logic [4:0] rdW_i,
  input  logic       regWriteM_i,
  input  logic       regWriteW_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (regWriteM_i && (rdM_i != 5'd0) && (rdM_i == rsE_i)) begin
      fwd_o = FWD_MEM;
    end else if (regWriteW_i && (rdW_i != 5'd0) && (rdW_i == rsE_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding, load-use and
// branch hazards, data-memory wait sequencing with a timeout watchdog.
// Define HAZ_PERF_CNT_EN to enable the stall/flush performance counters.
module hazard_ctrl
  import haz_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8,
  parameter int PERF_W  = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [4:0]        rs1D,
  input  logic [4:0]        rs2D,
  input  logic [4:0]        rs1E,
  input  logic [4:0]        rs2E,
  input  logic [4:0]        rdE,
  input  logic [4:0]        rdM,
  input  logic [4:0]        rdW,
  input  logic [1:0]        ResultSrcE,
  input  logic              regWriteM,
  input  logic              regWriteW,
  input  logic              pcSrcE,
  input  logic              memReqM,
  input  logic              memReadyM,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic              stallE,
  output logic              stallM,
  output logic              memFault,
  output logic [PERF_W-1:0] stallCnt,
  output logic [PERF_W-1:0] flushCnt
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic [1:0]       fwdA, fwdB;
  logic             lwStall, memMiss, memStall;

  fwd_sel u_fwdA (
    .rsE_i       (rs1E),
    .rdM_i       (rdM),
    .rdW_i       (rdW),
    .regWriteM_i (regWriteM),
    .regWriteW_i (regWriteW),
    .fwd_o       (fwdA)
  );

  fwd_sel u_fwdB (
    .rsE_i       (rs2E),
    .rdM_i       (rdM),
    .rdW_i       (rdW),
    .regWriteM_i (regWriteM),
    .regWriteW_i (regWriteW),
    .fwd_o       (fwdB)
  );

  assign lwStall  = (ResultSrcE == RESULT_SRC_LOAD) && (rdE != 5'd0) &&
                    ((rdE == rs1D) || (rdE == rs2D));
  assign memMiss  = memReqM && !memReadyM;
  assign memStall = memMiss || (state_q == FAULT);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= RUN;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // The wait counter reaching TIMEOUT while still not ready is the watchdog trip.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      RUN: begin
        if (memMiss) begin
          state_d   = MEM_WAIT;
          waitCnt_d = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (memReadyM || !memReqM) begin
          state_d   = RUN;
          waitCnt_d = '0;
        end else if (waitCnt_q == TIMEOUT_C) begin
          state_d = FAULT;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d   = RUN;
        waitCnt_d = '0;
      end
    endcase
  end

  // A memory stall freezes everything, so a branch resolved in E is held, not lost.
  always_comb begin
    forwardAE = fwdA;
    forwardBE = fwdB;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    memFault  = (state_q == FAULT);
    if (reset) begin
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;
      flushD    = 1'b1;
      flushE    = 1'b1;
    end else if (memStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (pcSrcE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (lwStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stallCnt_q, flushCnt_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stallF || stallM) stallCnt_q <= stallCnt_q + PERF_W'(1);
      if (flushE)           flushCnt_q <= flushCnt_q + PERF_W'(1);
    end
  end

  assign stallCnt = stallCnt_q;
  assign flushCnt = flushCnt_q;
`else
  assign stallCnt = '0;
  assign flushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven combinational vectors plus
// multi-cycle sequences for memory waits, timeout fault, reset and counters.
module tb_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0]  ResultSrcE;
  logic        regWriteM, regWriteW, pcSrcE, memReqM, memReadyM;
  logic [1:0]  forwardAE, forwardBE;
  logic        stallF, stallD, flushD, flushE, stallE, stallM, memFault;
  logic [31:0] stallCnt, flushCnt;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(8), .PERF_W(32)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .rs1D       (rs1D),
    .rs2D       (rs2D),
    .rs1E       (rs1E),
    .rs2E       (rs2E),
    .rdE        (rdE),
    .rdM        (rdM),
    .rdW        (rdW),
    .ResultSrcE (ResultSrcE),
    .regWriteM  (regWriteM),
    .regWriteW  (regWriteW),
    .pcSrcE     (pcSrcE),
    .memReqM    (memReqM),
    .memReadyM  (memReadyM),
    .forwardAE  (forwardAE),
    .forwardBE  (forwardBE),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushD     (flushD),
    .flushE     (flushE),
    .stallE     (stallE),
    .stallM     (stallM),
    .memFault   (memFault),
    .stallCnt   (stallCnt),
    .flushCnt   (flushCnt)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0] resSrc;
    logic       rwM, rwW, pc, req, rdy;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic [10:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_t;

  // Control field order: stallF stallD flushD flushE stallE stallM memFault
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LW   = 7'b1101000;
  localparam logic [6:0] C_BR   = 7'b0011000;
  localparam logic [6:0] C_MEM  = 7'b1100110;
  localparam logic [6:0] C_FLT  = 7'b1100111;
  localparam logic [6:0] C_RST  = 7'b0011000;

  sb_t expQ[$];
  int  compared   = 0;
  int  mismatched = 0;

  function automatic in_t mkIn(input int rst, input int r1D, input int r2D,
                               input int r1E, input int r2E, input int dE,
                               input int dM, input int dW, input int rs,
                               input int wM, input int wW, input int pc,
                               input int rq, input int ry);
    in_t v;
    v.rst = 1'(rst);  v.rs1D = 5'(r1D); v.rs2D = 5'(r2D);
    v.rs1E = 5'(r1E); v.rs2E = 5'(r2E); v.rdE = 5'(dE);
    v.rdM = 5'(dM);   v.rdW = 5'(dW);   v.resSrc = 2'(rs);
    v.rwM = 1'(wM);   v.rwW = 1'(wW);   v.pc = 1'(pc);
    v.req = 1'(rq);   v.rdy = 1'(ry);
    return v;
  endfunction

  function automatic logic [10:0] mkExp(input int a, input int b, input logic [6:0] c);
    return {2'(a), 2'(b), c};
  endfunction

  task automatic driveIn(input in_t v);
    reset = v.rst; rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
    rdE = v.rdE; rdM = v.rdM; rdW = v.rdW; ResultSrcE = v.resSrc;
    regWriteM = v.rwM; regWriteW = v.rwW; pcSrcE = v.pc;
    memReqM = v.req; memReadyM = v.rdy;
  endtask

  task automatic driveOnly(input in_t v);
    @(posedge CLK); #1;
    driveIn(v);
  endtask

  task automatic applyStimulus(input string name, input in_t v, input logic [10:0] exp);
    sb_t e;
    @(posedge CLK); #1;
    driveIn(v);
    e.name = name;
    e.exp  = exp;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    sb_t         e;
    logic [10:0] got;
    @(negedge CLK);
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard: no expectation queued");
      return;
    end
    e   = expQ.pop_front();
    got = {forwardAE, forwardBE, stallF, stallD, flushD, flushE, stallE, stallM, memFault};
    compared++;
    if (got !== e.exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b required %b", e.name, got, e.exp);
    end
  endtask

  task automatic step(input string name, input in_t v, input logic [10:0] exp);
    applyStimulus(name, v, exp);
    checkOutput();
  endtask

  task automatic compareVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  vec_t vecs[13];
  in_t  idle;

  initial begin
    idle = mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,0, 0,0);
    driveIn(mkIn(1, 0,0,0,0,0,0,0, 0, 0,0,0, 0,0));

    vecs[0]  = '{"fwdA_M_beats_W", mkIn(0, 0,0,5,0,0,5,5, 0, 1,1,0, 0,0), mkExp(2,0,C_NONE)};
    vecs[1]  = '{"fwdA_W",         mkIn(0, 0,0,5,0,0,5,5, 0, 0,1,0, 0,0), mkExp(1,0,C_NONE)};
    vecs[2]  = '{"fwd_rd_zero",    mkIn(0, 0,0,0,0,0,0,0, 0, 1,1,0, 0,0), mkExp(0,0,C_NONE)};
    vecs[3]  = '{"fwd_mixed",      mkIn(0, 0,0,3,9,0,9,3, 0, 1,1,0, 0,0), mkExp(1,2,C_NONE)};
    vecs[4]  = '{"fwd_both_M",     mkIn(0, 0,0,4,4,0,4,4, 0, 1,1,0, 0,0), mkExp(2,2,C_NONE)};
    vecs[5]  = '{"fwd_no_write",   mkIn(0, 0,0,6,6,0,6,6, 0, 0,0,0, 0,0), mkExp(0,0,C_NONE)};
    vecs[6]  = '{"lw_rs2",         mkIn(0, 0,7,0,0,7,0,0, 1, 0,0,0, 0,0), mkExp(0,0,C_LW)};
    vecs[7]  = '{"lw_rs1",         mkIn(0, 12,0,0,0,12,0,0, 1, 0,0,0, 0,0), mkExp(0,0,C_LW)};
    vecs[8]  = '{"lw_rdE_zero",    mkIn(0, 0,0,0,0,0,0,0, 1, 0,0,0, 0,0), mkExp(0,0,C_NONE)};
    vecs[9]  = '{"lw_not_load",    mkIn(0, 7,0,0,0,7,0,0, 2, 0,0,0, 0,0), mkExp(0,0,C_NONE)};
    vecs[10] = '{"branch_beats_lw",mkIn(0, 0,7,0,0,7,0,0, 1, 0,0,1, 0,0), mkExp(0,0,C_BR)};
    vecs[11] = '{"mem_ready_same", mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,0, 1,1), mkExp(0,0,C_NONE)};
    vecs[12] = '{"idle",           idle,                                   mkExp(0,0,C_NONE)};

    // Reset holds forwards at RF and flushes both front registers.
    step("reset_state", mkIn(1, 0,0,5,5,0,5,5, 0, 1,1,1, 1,0), mkExp(0,0,C_RST));

    for (int i = 0; i < 13; i++) step(vecs[i].name, vecs[i].in, vecs[i].exp);

    // Three wait cycles with a branch pending, then release lets the branch flush.
    for (int i = 0; i < 3; i++)
      step("mem_wait", mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,1, 1,0), mkExp(0,0,C_MEM));
    step("mem_release_branch", mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,1, 1,1), mkExp(0,0,C_BR));
    step("after_release", idle, mkExp(0,0,C_NONE));

    step("wait_then_drop", mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,0, 1,0), mkExp(0,0,C_MEM));
    step("req_dropped", idle, mkExp(0,0,C_NONE));
    step("run_after_drop", mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,0, 1,1), mkExp(0,0,C_NONE));

    // Timeout: RUN cycle plus four MEM_WAIT cycles, then FAULT.
    for (int i = 0; i < 5; i++)
      step("timeout_wait", mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,0, 1,0), mkExp(0,0,C_MEM));
    step("fault_raised", mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,0, 1,0), mkExp(0,0,C_FLT));
    step("fault_sticky", mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,1, 0,1), mkExp(0,0,C_FLT));
    step("fault_sticky2", idle, mkExp(0,0,C_FLT));

    driveOnly(mkIn(1, 0,0,5,5,0,5,5, 0, 1,1,0, 1,0));
    step("reset_from_fault", mkIn(1, 0,0,5,5,0,5,5, 0, 1,1,0, 1,0), mkExp(0,0,C_RST));
    step("run_after_reset", idle, mkExp(0,0,C_NONE));
    step("no_fault_after_reset", mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,0, 1,1), mkExp(0,0,C_NONE));

    // Counter scenario: two load-use stalls and one branch since the last reset.
    step("perf_lw1", mkIn(0, 0,7,0,0,7,0,0, 1, 0,0,0, 0,0), mkExp(0,0,C_LW));
    step("perf_lw2", mkIn(0, 3,0,0,0,3,0,0, 1, 0,0,0, 0,0), mkExp(0,0,C_LW));
    step("perf_br",  mkIn(0, 0,0,0,0,0,0,0, 0, 0,0,1, 0,0), mkExp(0,0,C_BR));
    step("perf_idle", idle, mkExp(0,0,C_NONE));
`ifdef HAZ_PERF_CNT_EN
    compareVal("stallCnt", stallCnt, 32'd2);
    compareVal("flushCnt", flushCnt, 32'd3);
`else
    compareVal("stallCnt_tied", stallCnt, 32'd0);
    compareVal("flushCnt_tied", flushCnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
